data_wr_buffer: RTL and testbench

- Store buffer on the data SRAM-like path, downstream of cpu_core and upstream of axi_bridge.
- Accepts core stores immediately into a small FIFO and acks them one cycle later.
- Drains buffered stores to the bridge in order.
- Serialises loads against buffered stores so ordering and RAW correctness hold; one downstream transaction in flight at a time.

---
 rtl/data_wr_buffer_pkg.sv | 26 ++
 rtl/data_wr_buffer_fifo.sv | 70 +++++++
 rtl/data_wr_buffer.sv | 178 +++++++++++++++++
 tb/tb_data_wr_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_wr_buffer_pkg.sv
// Shared definitions for the data store buffer: FSM states, access sizes,
// default FIFO depth and the layout of one buffered store.
package data_wr_buffer_pkg;

    localparam int DEFAULT_DEPTH = 4;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WREQ  = 3'd1,
        S_WRESP = 3'd2,
        S_RREQ  = 3'd3,
        S_RRESP = 3'd4
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } wbuf_entry_t;

endpackage

// File: rtl/data_wr_buffer_fifo.sv
// wbuf_fifo: in-order storage for buffered stores. With DATA_WR_BUFFER_BYPASS_EN
// it also reports which valid entries hit a given word address.
module wbuf_fifo
    import data_wr_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push_i,
    input  wbuf_entry_t       push_data_i,
    input  logic              pop_i,
    output wbuf_entry_t       head_o,
`ifdef DATA_WR_BUFFER_BYPASS_EN
    input  logic [29:0]       match_addr_i,
    output logic [DEPTH-1:0]  match_o,
`endif
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [PW:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= push_data_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == (PW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);

`ifdef DATA_WR_BUFFER_BYPASS_EN
    // An entry is live when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] offset;
        match_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset     = PW'(i) - rdPtr_q;
            match_o[i] = ({1'b0, offset} < count_q) && (mem_q[i].addr[31:2] == match_addr_i);
        end
    end
`endif

endmodule

// File: rtl/data_wr_buffer.sv
// Store buffer between the core data port and the AXI bridge. Define
// DATA_WR_BUFFER_BYPASS_EN to let loads overtake buffered stores to other words.
module data_wr_buffer
    import data_wr_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        ldPend_q, ldPend_d;
    logic [31:0] ldAddr_q, ldAddr_d;
    logic [1:0]  ldSize_q, ldSize_d;
    logic        memWr_q, memWr_d;
    logic [1:0]  memSize_q, memSize_d;
    logic [3:0]  memWstrb_q, memWstrb_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic        wack_q;

    wbuf_entry_t pushEntry, headEntry;
    logic        fifoFull, fifoEmpty;
    logic        storeAcc, loadAcc, pop, rdDone;
    logic        rdBusy, wrBusy, ldClear;

    assign pushEntry = '{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata};

`ifdef DATA_WR_BUFFER_BYPASS_EN
    logic [DEPTH-1:0] entryMatch;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (storeAcc),
        .push_data_i  (pushEntry),
        .pop_i        (pop),
        .head_o       (headEntry),
        .match_addr_i (cpu_addr[31:2]),
        .match_o      (entryMatch),
        .full_o       (fifoFull),
        .empty_o      (fifoEmpty)
    );

    // The store in flight downstream is still in the FIFO, but its copy in the
    // mem_* registers is checked too so a hit can never slip through.
    assign ldClear = ~|entryMatch && !(wrBusy && (memAddr_q[31:2] == cpu_addr[31:2]));
`else
    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (storeAcc),
        .push_data_i (pushEntry),
        .pop_i       (pop),
        .head_o      (headEntry),
        .full_o      (fifoFull),
        .empty_o     (fifoEmpty)
    );

    assign ldClear = fifoEmpty && !wrBusy;
`endif

    assign wrBusy   = (state_q == S_WREQ) || (state_q == S_WRESP);
    assign rdBusy   = (state_q == S_RREQ) || (state_q == S_RRESP) || ldPend_q;
    assign storeAcc = cpu_req && cpu_wr && !fifoFull && !rdBusy;
    assign loadAcc  = cpu_req && !cpu_wr && !rdBusy && ldClear;
    assign pop      = (state_q == S_WRESP) && mem_data_ok;
    assign rdDone   = (state_q == S_RRESP) && mem_data_ok;

    assign cpu_addr_ok = storeAcc || loadAcc;
    assign cpu_data_ok = wack_q || rdDone;
    assign cpu_rdata   = rdDone ? mem_rdata : '0;

    assign mem_req   = (state_q == S_WREQ) || (state_q == S_RREQ);
    assign mem_wr    = memWr_q;
    assign mem_size  = memSize_q;
    assign mem_wstrb = memWstrb_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

    // The mem_* registers only load in S_IDLE, which keeps them stable while mem_req is high.
    always_comb begin
        state_d    = state_q;
        ldPend_d   = ldPend_q;
        ldAddr_d   = ldAddr_q;
        ldSize_d   = ldSize_q;
        memWr_d    = memWr_q;
        memSize_d  = memSize_q;
        memWstrb_d = memWstrb_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;

        case (state_q)
            S_IDLE: begin
                if (ldPend_q) begin
                    ldPend_d   = 1'b0;
                    memWr_d    = 1'b0;
                    memSize_d  = ldSize_q;
                    memWstrb_d = '0;
                    memAddr_d  = ldAddr_q;
                    memWdata_d = '0;
                    state_d    = S_RREQ;
                end else if (loadAcc) begin
                    memWr_d    = 1'b0;
                    memSize_d  = cpu_size;
                    memWstrb_d = '0;
                    memAddr_d  = cpu_addr;
                    memWdata_d = '0;
                    state_d    = S_RREQ;
                end else if (!fifoEmpty) begin
                    memWr_d    = 1'b1;
                    memSize_d  = headEntry.size;
                    memWstrb_d = headEntry.wstrb;
                    memAddr_d  = headEntry.addr;
                    memWdata_d = headEntry.wdata;
                    state_d    = S_WREQ;
                end
            end
            S_WREQ:  if (mem_addr_ok) state_d = S_WRESP;
            S_WRESP: if (mem_data_ok) state_d = S_IDLE;
            S_RREQ:  if (mem_addr_ok) state_d = S_RRESP;
            S_RRESP: if (mem_data_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (loadAcc && (state_q != S_IDLE)) begin
            ldPend_d = 1'b1;
            ldAddr_d = cpu_addr;
            ldSize_d = cpu_size;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ldPend_q   <= 1'b0;
            ldAddr_q   <= '0;
            ldSize_q   <= '0;
            memWr_q    <= 1'b0;
            memSize_q  <= '0;
            memWstrb_q <= '0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            wack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ldPend_q   <= ldPend_d;
            ldAddr_q   <= ldAddr_d;
            ldSize_q   <= ldSize_d;
            memWr_q    <= memWr_d;
            memSize_q  <= memSize_d;
            memWstrb_q <= memWstrb_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            wack_q     <= storeAcc;
        end
    end

endmodule

// File: tb/tb_data_wr_buffer.sv
// Directed bench for data_wr_buffer: a simple bridge model logs downstream
// transactions so their order and contents can be checked.
module tb_data_wr_buffer;
    import data_wr_buffer_pkg::*;

    logic        clk, resetn;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int numCompared = 0;
    int numMismatched = 0;

    bit          manualMode = 0;
    bit          bridgeEn = 0;
    bit          bBusy;
    int          bWait;
    logic        pendWr;
    logic [31:0] pendAddr;
    logic [31:0] memModel [logic [31:0]];
    logic        logWr [$];
    logic [31:0] logAddr [$];
    logic [31:0] logData [$];

    data_wr_buffer dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_wstrb(cpu_wstrb),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] readModel(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return ~a;
    endfunction

    // Bridge model: addr_ok one cycle after seeing mem_req, data_ok two cycles later.
    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        bBusy = 0;
        bWait = 0;
        forever begin
            @(negedge clk);
            if (!manualMode) begin
                mem_addr_ok = 1'b0;
                mem_data_ok = 1'b0;
                mem_rdata   = '0;
                if (!resetn) begin
                    bBusy = 0;
                end else if (bBusy) begin
                    bWait--;
                    if (bWait == 0) begin
                        mem_data_ok = 1'b1;
                        bBusy = 0;
                        if (!pendWr) mem_rdata = readModel(pendAddr);
                    end
                end else if (bridgeEn && mem_req) begin
                    mem_addr_ok = 1'b1;
                    bBusy = 1;
                    bWait = 2;
                    pendWr = mem_wr;
                    pendAddr = mem_addr;
                    logWr.push_back(mem_wr);
                    logAddr.push_back(mem_addr);
                    logData.push_back(mem_wdata);
                    if (mem_wr) memModel[mem_addr] = mem_wdata;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        cpu_req   = req;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        cpu_size  = SIZE_W;
        #1;
    endtask

    task automatic clearLog();
        logWr.delete();
        logAddr.delete();
        logData.delete();
    endtask

    task automatic pushStore(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data, 4'hF);
        checkOutput("st_addr_ok", cpu_addr_ok, 1);
        cyc();
        checkOutput("st_data_ok", cpu_data_ok, 1);
    endtask

    task automatic waitAddrOk(input int limit);
        int waited = 0;
        while (!cpu_addr_ok && waited < limit) begin
            cyc();
            waited++;
        end
        if (!cpu_addr_ok) checkOutput("addr_ok_timeout", 0, 1);
    endtask

    task automatic waitDataOk(input int limit, output logic [31:0] rdata);
        int waited = 0;
        while (!cpu_data_ok && waited < limit) begin
            cyc();
            waited++;
        end
        if (!cpu_data_ok) checkOutput("data_ok_timeout", 0, 1);
        rdata = cpu_rdata;
    endtask

    task automatic waitDrained(input int limit);
        int waited = 0;
        while (!(dut.u_fifo.count_q == 0 && dut.state_q == S_IDLE) && waited < limit) begin
            cyc();
            waited++;
        end
        checkOutput("drained", (dut.u_fifo.count_q == 0 && dut.state_q == S_IDLE), 1);
    endtask

    task automatic checkLog(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        if (idx < logAddr.size()) begin
            checkOutput($sformatf("log%0d_wr", idx), logWr[idx], wr);
            checkOutput($sformatf("log%0d_addr", idx), logAddr[idx], addr);
            if (wr) checkOutput($sformatf("log%0d_wdata", idx), logData[idx], data);
        end else begin
            checkOutput($sformatf("log%0d_missing", idx), 0, 1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        repeat (2) cyc();

        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_wr", mem_wr, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_cpu_data_ok", cpu_data_ok, 0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 0);
        resetn = 1'b1;
        cyc();

        // Fill the FIFO while the bridge stalls, then try a fifth store.
        for (int i = 0; i < 4; i++) pushStore(32'h100 + 4 * i, 32'hA500_0000 + i);
        applyStimulus(1'b1, 1'b1, 32'h110, 32'hA500_0004, 4'hF);
        checkOutput("full_addr_ok", cpu_addr_ok, 0);
        cyc();
        checkOutput("full_no_ack", cpu_data_ok, 0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("full_count", dut.u_fifo.count_q, 4);
        checkOutput("stall_mem_req", mem_req, 1);
        checkOutput("stall_mem_wr", mem_wr, 1);
        checkOutput("stall_mem_addr", mem_addr, 32'h100);
        checkOutput("stall_mem_wdata", mem_wdata, 32'hA500_0000);

        // Release the bridge and drain in order.
        bridgeEn = 1;
        waitDrained(80);
        checkOutput("drain_log_size", logAddr.size(), 4);
        for (int i = 0; i < 4; i++) checkLog(i, 1'b1, 32'h100 + 4 * i, 32'hA500_0000 + i);
        checkOutput("drain_mem_req", mem_req, 0);
        clearLog();

        // Load after a store to the same word waits for the drain.
        pushStore(32'h200, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, 32'h200, '0, '0);
        checkOutput("raw_stall", cpu_addr_ok, 0);
        waitAddrOk(60);
        checkOutput("raw_accept_count", dut.u_fifo.count_q, 0);
        checkOutput("raw_store_first", logAddr.size(), 1);
        cyc();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("ld_lat_mem_req", mem_req, 1);
        checkOutput("ld_lat_mem_wr", mem_wr, 0);
        checkOutput("ld_lat_mem_addr", mem_addr, 32'h200);
        waitDataOk(40, rd);
        checkOutput("raw_rdata", rd, 32'hDEAD_BEEF);
        cyc();
        checkOutput("raw_no_extra_ok", cpu_data_ok, 0);
        bridgeEn = 0;
        clearLog();

        // Loads against three buffered stores.
        for (int i = 0; i < 3; i++) pushStore(32'h300 + 4 * i, 32'hC000_0000 + i);
        applyStimulus(1'b1, 1'b0, 32'h400, '0, '0);
`ifdef DATA_WR_BUFFER_BYPASS_EN
        checkOutput("byp_ld_accept", cpu_addr_ok, 1);
        cyc();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        bridgeEn = 1;
`else
        checkOutput("ord_ld_stall", cpu_addr_ok, 0);
        bridgeEn = 1;
        waitAddrOk(80);
        cyc();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
`endif
        waitDataOk(80, rd);
        checkOutput("ld400_rdata", rd, 32'hFFFF_FBFF);
        cyc();
        applyStimulus(1'b1, 1'b0, 32'h304, '0, '0);
        waitAddrOk(80);
        cyc();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        waitDataOk(40, rd);
        checkOutput("ld304_rdata", rd, 32'hC000_0001);
        cyc();
        waitDrained(80);
        checkOutput("ord_log_size", logAddr.size(), 5);
`ifdef DATA_WR_BUFFER_BYPASS_EN
        checkLog(0, 1'b1, 32'h300, 32'hC000_0000);
        checkLog(1, 1'b0, 32'h400, '0);
        checkLog(2, 1'b1, 32'h304, 32'hC000_0001);
        checkLog(3, 1'b0, 32'h304, '0);
        checkLog(4, 1'b1, 32'h308, 32'hC000_0002);
`else
        checkLog(0, 1'b1, 32'h300, 32'hC000_0000);
        checkLog(1, 1'b1, 32'h304, 32'hC000_0001);
        checkLog(2, 1'b1, 32'h308, 32'hC000_0002);
        checkLog(3, 1'b0, 32'h400, '0);
        checkLog(4, 1'b0, 32'h304, '0);
`endif
        bridgeEn = 0;
        clearLog();

        // Push in the same cycle that S_WRESP pops the head.
        for (int i = 0; i < 3; i++) pushStore(32'h500 + 4 * i, 32'hE000_0000 + i);
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("pp_count_before", dut.u_fifo.count_q, 3);
        checkOutput("pp_head_addr", mem_addr, 32'h500);
        manualMode = 1;
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h50C, 32'hE000_0003, 4'hF);
        checkOutput("pp_addr_ok", cpu_addr_ok, 1);
        cyc();
        mem_data_ok = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        checkOutput("pp_count_after", dut.u_fifo.count_q, 3);
        checkOutput("pp_ack", cpu_data_ok, 1);
        manualMode = 0;
        bridgeEn = 1;
        waitDrained(80);
        checkOutput("pp_log_size", logAddr.size(), 3);
        for (int i = 0; i < 3; i++) checkLog(i, 1'b1, 32'h504 + 4 * i, 32'hE000_0001 + i);
        bridgeEn = 0;
        clearLog();

        // Reset while a load sits in S_RRESP.
        manualMode = 1;
`ifdef DATA_WR_BUFFER_BYPASS_EN
        for (int i = 0; i < 3; i++) pushStore(32'h600 + 4 * i, 32'hF000_0000 + i);
        applyStimulus(1'b1, 1'b0, 32'h700, '0, '0);
        checkOutput("rr_ld_accept", cpu_addr_ok, 1);
        cyc();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        cyc();
        mem_data_ok = 1'b0;
        cyc();
`else
        applyStimulus(1'b1, 1'b0, 32'h700, '0, '0);
        checkOutput("rr_ld_accept", cpu_addr_ok, 1);
        cyc();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
`endif
        checkOutput("rr_mem_req", mem_req, 1);
        checkOutput("rr_mem_addr", mem_addr, 32'h700);
        mem_addr_ok = 1'b1;
        cyc();
        mem_addr_ok = 1'b0;
        checkOutput("rr_in_rresp", dut.state_q == S_RRESP, 1);
`ifdef DATA_WR_BUFFER_BYPASS_EN
        checkOutput("rr_count_before", dut.u_fifo.count_q, 2);
`endif
        resetn = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        checkOutput("rr_rst_mem_req", mem_req, 0);
        checkOutput("rr_rst_data_ok", cpu_data_ok, 0);
        checkOutput("rr_rst_rdata", cpu_rdata, 0);
        mem_data_ok = 1'b0;
        cyc();
        resetn = 1'b1;
        manualMode = 0;
        cyc();
        cyc();
        checkOutput("rr_post_count", dut.u_fifo.count_q, 0);
        checkOutput("rr_post_idle", dut.state_q == S_IDLE, 1);
        checkOutput("rr_post_mem_req", mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
